// File: rtl/syscall_unit_pkg.sv
// Shared constants and state encoding for the syscall service unit.
package syscall_unit_pkg;

   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   typedef enum logic [3:0] {
      IDLE,
      INT_SIGN,
      INT_CONV,
      INT_EMIT,
      STR_REQ,
      STR_WAIT,
      STR_EMIT,
      CHAR_EMIT,
      HALTED
   } state_t;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/syscall_unit_int_to_dec.sv
// Sequential binary-to-decimal converter: pushes one digit per cycle onto a
// 10-entry stack (LSD first) so the caller can pop them MSD first.
module syscall_unit_int_to_dec (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] mag,
   input  logic        pop,
   output logic        busy,
   output logic        digit_valid,
   output logic [3:0]  digit
);

   logic [31:0] m_q;
   logic [3:0]  stk_q [10];
   logic [3:0]  cnt_q;
   logic [31:0] quot;
   logic [3:0]  rem;

   assign quot = m_q / 32'd10;
   assign rem  = 4'(m_q % 32'd10);

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q   <= 32'd0;
         cnt_q <= 4'd0;
         busy  <= 1'b0;
      end else if (start) begin
         m_q   <= mag;
         cnt_q <= 4'd0;
         busy  <= 1'b1;
      end else if (busy) begin
         // a zero magnitude still pushes a single '0' digit
         stk_q[cnt_q] <= rem;
         cnt_q        <= cnt_q + 4'd1;
         m_q          <= quot;
         busy         <= (quot != 32'd0);
      end else if (pop && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign digit_valid = !busy && (cnt_q != 4'd0);
   assign digit       = (cnt_q != 4'd0) ? stk_q[cnt_q - 4'd1] : 4'd0;

endmodule

// File: rtl/syscall_unit.sv
// SPIM-style syscall service: print-int/string/char and exit, streaming ASCII
// on a ready/valid console port and stalling the pipeline until done.
//
// state     | meaning
// IDLE      | waiting for a SYSCALL
// INT_SIGN  | '-' pending (negative a0), then start digit conversion
// INT_CONV  | converter pushing digits
// INT_EMIT  | popping digits MSD first onto the console
// STR_REQ   | one-cycle byte read request at ptr
// STR_WAIT  | memory latency countdown, then capture byte
// STR_EMIT  | string byte pending on the console
// CHAR_EMIT | single character pending on the console
// HALTED    | program exited; only rst leaves
module syscall_unit
   import syscall_unit_pkg::*;
#(
   parameter int MAX_STR = 256,
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic        out_valid,
   output logic [7:0]  out_char,
   input  logic        out_ready,
   output logic        stall,
   output logic        halt,
   output logic        err
);

   localparam int         CNT_W    = $clog2(MAX_STR + 1);
   localparam logic [7:0] LAT_LOAD = 8'(MEM_LAT - 1);

   state_t             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [7:0]         out_char_q, out_char_d;
   logic [31:0]        ptr_q, ptr_d;
   logic [31:0]        arg_q, arg_d;
   logic [CNT_W-1:0]   left_q, left_d;
   logic [7:0]         wait_q, wait_d;
   logic               err_q, err_d;
   logic               halt_q, halt_d;
   logic               conv_start, conv_pop, conv_busy, digit_valid;
   logic [3:0]         digit;

   syscall_unit_int_to_dec u_int_to_dec (
      .clk         (clk),
      .rst         (rst),
      .start       (conv_start),
      .mag         (abs32(arg_q)),
      .pop         (conv_pop),
      .busy        (conv_busy),
      .digit_valid (digit_valid),
      .digit       (digit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'd0;
         ptr_q       <= 32'd0;
         arg_q       <= 32'd0;
         left_q      <= '0;
         wait_q      <= 8'd0;
         err_q       <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_char_q  <= out_char_d;
         ptr_q       <= ptr_d;
         arg_q       <= arg_d;
         left_q      <= left_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         halt_q      <= halt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_char_d  = out_char_q;
      ptr_d       = ptr_q;
      arg_d       = arg_q;
      left_d      = left_q;
      wait_d      = wait_q;
      err_d       = 1'b0;
      halt_d      = halt_q;
      conv_start  = 1'b0;
      conv_pop    = 1'b0;
      case (state_q)
         IDLE: if (syscall) begin
            arg_d = a0;
            case (v0)
               SYS_PRINT_INT: begin
                  state_d = INT_SIGN;
                  if (a0[31]) begin
                     out_valid_d = 1'b1;
                     out_char_d  = ASCII_MINUS;
                  end
               end
               SYS_PRINT_STR: begin
                  state_d = STR_REQ;
                  ptr_d   = a0;
                  left_d  = CNT_W'(MAX_STR);
               end
               SYS_PRINT_CHAR: begin
                  state_d     = CHAR_EMIT;
                  out_valid_d = 1'b1;
                  out_char_d  = a0[7:0];
               end
               SYS_EXIT: begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end
               default: err_d = 1'b1;
            endcase
         end
         INT_SIGN: if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b0;
            conv_start  = 1'b1;
            state_d     = INT_CONV;
         end
         INT_CONV: if (!conv_busy) state_d = INT_EMIT;
         INT_EMIT: if (!out_valid_q || out_ready) begin
            // refill in the transfer cycle keeps a steady 1 char/cycle
            if (digit_valid) begin
               conv_pop    = 1'b1;
               out_valid_d = 1'b1;
               out_char_d  = ASCII_ZERO + {4'd0, digit};
            end else begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         STR_REQ: begin
            state_d = STR_WAIT;
            wait_d  = LAT_LOAD;
         end
         STR_WAIT: begin
            if (wait_q == 8'd0) begin
               if (mem_rdata == 8'd0) begin
                  state_d = IDLE;
               end else begin
                  out_valid_d = 1'b1;
                  out_char_d  = mem_rdata;
                  state_d     = STR_EMIT;
               end
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         STR_EMIT: if (out_ready) begin
            out_valid_d = 1'b0;
            ptr_d       = ptr_q + 32'd1;
            if (left_q == CNT_W'(1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               left_d  = left_q - CNT_W'(1);
               state_d = STR_REQ;
            end
         end
         CHAR_EMIT: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         HALTED: out_valid_d = 1'b0;
         default: state_d = IDLE;
      endcase
   end

   assign mem_req   = (state_q == STR_REQ);
   assign mem_addr  = ptr_q;
   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign halt      = halt_q;
   assign err       = err_q;
   assign stall     = (state_q != IDLE) | (syscall & (state_q == IDLE)) | halt_q;

endmodule
